// File: rtl/axis_frame_pkg.sv
// Shared constants, helper functions and FSM state type for the AXI-Stream frame packer.
// Frame layout helpers are evaluated at elaboration time from the top-level parameters.
package axis_frame_pkg;

    // Upper bound on stream byte lanes supported by last_keep()
    localparam int unsigned KEEP_MAX = 256;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int unsigned frame_bits(
        input int unsigned data_w,
        input int unsigned seq_w
    );
        return data_w + seq_w;
    endfunction

    function automatic int unsigned beats(
        input int unsigned data_w,
        input int unsigned seq_w,
        input int unsigned axis_w
    );
        return (frame_bits(data_w, seq_w) + axis_w - 1) / axis_w;
    endfunction

    function automatic int unsigned last_bytes(
        input int unsigned data_w,
        input int unsigned seq_w,
        input int unsigned axis_w
    );
        return (frame_bits(data_w, seq_w) - (beats(data_w, seq_w, axis_w) - 1) * axis_w) / 8;
    endfunction

    function automatic logic [KEEP_MAX-1:0] last_keep(input int unsigned nbytes);
        logic [KEEP_MAX-1:0] keep;
        keep = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            if (i < nbytes) begin
                keep[i] = 1'b1;
            end
        end
        return keep;
    endfunction

endpackage

// File: rtl/axis_frame_fifo.sv
// Synchronous DEPTH x WIDTH frame FIFO with level output; read data is the current head entry.
// Push is ignored when full and pop when empty, so callers may gate loosely.
module axis_frame_fifo #(
    parameter int unsigned WIDTH = 4064,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W + 1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_FULL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_frame_packer.sv
// Packs wide frames plus a sequence header into AXI-Stream C2H beats with byte-accurate tkeep.
// Frames are buffered in a small FIFO and streamed back to back with no idle beat between them.
module axis_frame_packer
    import axis_frame_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 4064,
    parameter int unsigned AXIS_DATA_WIDTH = 512,
    parameter int unsigned SEQ_WIDTH       = 8,
    parameter int unsigned DEPTH           = 4
) (
    input  logic                         m_axis_c2h_aclk,
    input  logic                         m_axis_c2h_aresetn,
    input  logic [DATA_WIDTH-1:0]        data,
    input  logic                         data_valid,
    output logic                         data_ready,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_c2h_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_c2h_tkeep,
    output logic                         m_axis_c2h_tlast,
    output logic                         m_axis_c2h_tvalid,
    input  logic                         m_axis_c2h_tready,
    output logic [$clog2(DEPTH):0]       fifo_level,
    output logic [31:0]                  frames_sent
);

    localparam int unsigned FRAME_BITS = frame_bits(DATA_WIDTH, SEQ_WIDTH);
    localparam int unsigned BEATS      = beats(DATA_WIDTH, SEQ_WIDTH, AXIS_DATA_WIDTH);
    localparam int unsigned LAST_BYTES = last_bytes(DATA_WIDTH, SEQ_WIDTH, AXIS_DATA_WIDTH);
    localparam int unsigned KEEP_W     = AXIS_DATA_WIDTH / 8;
    localparam int unsigned SHIFT_W    = BEATS * AXIS_DATA_WIDTH;
    localparam int unsigned BIDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [KEEP_MAX-1:0] KEEP_LAST_ALL = last_keep(LAST_BYTES);
    localparam logic [KEEP_W-1:0]   KEEP_LAST     = KEEP_LAST_ALL[KEEP_W-1:0];
    localparam logic [KEEP_W-1:0]   KEEP_ALL      = '1;
    localparam logic [BIDX_W-1:0]   LAST_IDX      = BIDX_W'(BEATS - 1);
    localparam logic                SINGLE_BEAT   = (BEATS == 1);

    if ((AXIS_DATA_WIDTH % 8) != 0) begin : g_chk_axis
        $error("AXIS_DATA_WIDTH must be a multiple of 8");
    end
    if ((FRAME_BITS % 8) != 0) begin : g_chk_frame
        $error("DATA_WIDTH + SEQ_WIDTH must be a multiple of 8");
    end
    if (KEEP_W > KEEP_MAX) begin : g_chk_keep
        $error("AXIS_DATA_WIDTH exceeds supported byte lanes");
    end

    state_t              r_state;
    logic [SHIFT_W-1:0]  r_shift;
    logic [BIDX_W-1:0]   r_beat_idx;
    logic [SEQ_WIDTH-1:0] r_seq;
    logic [31:0]         r_frames_sent;
    logic                r_tvalid;
    logic                r_tlast;
    logic [KEEP_W-1:0]   r_tkeep;

    logic [DATA_WIDTH-1:0] w_fifo_dout;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_beat_done;
    logic                  w_frame_done;
    logic                  w_load;
    logic [BIDX_W-1:0]     w_idx_next;
    logic                  w_next_is_last;
    logic [SHIFT_W-1:0]    w_frame;

    // Held low during reset so the source never sees a stale ready
    assign data_ready     = m_axis_c2h_aresetn && !w_fifo_full;
    assign w_push         = data_valid && data_ready;
    assign w_beat_done    = r_tvalid && m_axis_c2h_tready;
    assign w_frame_done   = w_beat_done && (r_beat_idx == LAST_IDX);
    // A new frame is loaded from IDLE or on the final handshake, giving zero-bubble chaining
    assign w_load         = !w_fifo_empty && ((r_state == IDLE) || w_frame_done);
    assign w_idx_next     = r_beat_idx + 1'b1;
    assign w_next_is_last = (w_idx_next == LAST_IDX);

    always_comb begin
        w_frame = '0;
        w_frame[FRAME_BITS-1:0] = {w_fifo_dout, r_seq};
    end

    axis_frame_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (m_axis_c2h_aclk),
        .i_rst_n (m_axis_c2h_aresetn),
        .i_push  (w_push),
        .i_din   (data),
        .i_pop   (w_load),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
        if (!m_axis_c2h_aresetn) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_beat_idx    <= '0;
            r_seq         <= '0;
            r_frames_sent <= '0;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_tkeep       <= '0;
        end else begin
            if (w_load) begin
                r_state    <= SEND;
                r_shift    <= w_frame;
                r_beat_idx <= '0;
                r_seq      <= r_seq + 1'b1;
                r_tvalid   <= 1'b1;
                r_tlast    <= SINGLE_BEAT;
                r_tkeep    <= SINGLE_BEAT ? KEEP_LAST : KEEP_ALL;
            end else if (w_frame_done) begin
                r_state    <= IDLE;
                r_tvalid   <= 1'b0;
                r_tlast    <= 1'b0;
                r_tkeep    <= '0;
            end else if (w_beat_done) begin
                r_shift    <= r_shift >> AXIS_DATA_WIDTH;
                r_beat_idx <= w_idx_next;
                r_tlast    <= w_next_is_last;
                r_tkeep    <= w_next_is_last ? KEEP_LAST : KEEP_ALL;
            end
            if (w_frame_done) begin
                r_frames_sent <= r_frames_sent + 32'd1;
            end
        end
    end

    assign m_axis_c2h_tdata  = r_shift[AXIS_DATA_WIDTH-1:0];
    assign m_axis_c2h_tkeep  = r_tkeep;
    assign m_axis_c2h_tlast  = r_tlast;
    assign m_axis_c2h_tvalid = r_tvalid;
    assign frames_sent       = r_frames_sent;

endmodule

// File: tb/tb_axis_frame_packer.sv
// Randomised self-checking bench for axis_frame_packer against a frame-level scoreboard.
module tb_axis_frame_packer;

    localparam int DW    = 4064;
    localparam int AW    = 512;
    localparam int SW    = 8;
    localparam int DEP   = 4;
    localparam int FB    = DW + SW;
    localparam int BEATS = (FB + AW - 1) / AW;
    localparam int KW    = AW / 8;
    localparam int LW    = $clog2(DEP) + 1;
    localparam int PAD_LO = FB - (BEATS - 1) * AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] data = '0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic [AW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tlast;
    logic          tvalid;
    logic          tready = 1'b0;
    logic [LW-1:0] fifo_level;
    logic [31:0]   frames_sent;

    int n_checks = 0;
    int n_errors = 0;

    int tready_mode = 0;
    int cyc = 0;

    logic [AW-1:0] exp_data [$];
    logic [KW-1:0] exp_keep [$];
    bit            exp_last [$];
    logic [SW-1:0] mdl_seq = '0;
    int            mdl_frames = 0;

    logic [SW-1:0] rx_seq [$];
    int            hs_count = 0;
    int            hs_first = 0;
    int            hs_last = 0;
    int            stab_viol = 0;
    int            beat_pos = 0;
    bit            prev_stall = 0;
    logic [AW-1:0] prev_data, last_data;
    logic [KW-1:0] prev_keep, last_keep;
    logic          prev_last;

    axis_frame_packer #(
        .DATA_WIDTH      (DW),
        .AXIS_DATA_WIDTH (AW),
        .SEQ_WIDTH       (SW),
        .DEPTH           (DEP)
    ) dut (
        .m_axis_c2h_aclk    (clk),
        .m_axis_c2h_aresetn (rst_n),
        .data               (data),
        .data_valid         (data_valid),
        .data_ready         (data_ready),
        .m_axis_c2h_tdata   (tdata),
        .m_axis_c2h_tkeep   (tkeep),
        .m_axis_c2h_tlast   (tlast),
        .m_axis_c2h_tvalid  (tvalid),
        .m_axis_c2h_tready  (tready),
        .fifo_level         (fifo_level),
        .frames_sent        (frames_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (tready_mode)
            0:       tready = 1'b0;
            1:       tready = 1'b1;
            default: tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Stream monitor: scoreboards every handshake and watches stall stability
    always @(negedge clk) begin : monitor
        logic [AW-1:0] ed;
        logic [KW-1:0] ek;
        bit            el;
        if (!rst_n) begin
            beat_pos   = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall && (!tvalid || tdata !== prev_data || tkeep !== prev_keep || tlast !== prev_last))
                stab_viol++;
            if (tvalid && tready) begin
                n_checks++;
                if (exp_data.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_beat: got beat tlast=%b tkeep=%h, required no beat", tlast, tkeep);
                end else begin
                    ed = exp_data.pop_front();
                    ek = exp_keep.pop_front();
                    el = exp_last.pop_front();
                    if (tdata !== ed || tkeep !== ek || tlast !== el) begin
                        n_errors++;
                        $display("FAIL beat_payload: got keep=%h last=%b data=%h, required keep=%h last=%b data=%h",
                                 tkeep, tlast, tdata, ek, el, ed);
                    end
                end
                if (beat_pos == 0) rx_seq.push_back(tdata[SW-1:0]);
                beat_pos = tlast ? 0 : beat_pos + 1;
                hs_count++;
                if (hs_count == 1) hs_first = cyc;
                hs_last   = cyc;
                last_data = tdata;
                last_keep = tkeep;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_keep  = tkeep;
            prev_last  = tlast;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: frame = {zero pad, payload, seq}; keep covers the bytes still left in the frame
    task automatic model_accept(input logic [DW-1:0] d);
        logic [BEATS*AW-1:0] f;
        logic [KW-1:0]       k;
        int                  rem;
        f = '0;
        f[FB-1:0] = {d, mdl_seq};
        for (int b = 0; b < BEATS; b++) begin
            rem = FB / 8 - b * KW;
            for (int i = 0; i < KW; i++) k[i] = (i < rem);
            exp_data.push_back(f[b*AW +: AW]);
            exp_keep.push_back(k);
            exp_last.push_back(b == BEATS - 1);
        end
        mdl_seq++;
        mdl_frames++;
    endtask

    task automatic model_clear();
        exp_data.delete();
        exp_keep.delete();
        exp_last.delete();
        mdl_seq    = '0;
        mdl_frames = 0;
    endtask

    function automatic logic [DW-1:0] rand_frame();
        logic [DW+31:0] t;
        t = '0;
        for (int i = 0; i < DW; i += 32) t[i +: 32] = $urandom;
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] ramp_frame();
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < DW / 8; i++) d[i*8 +: 8] = 8'(i);
        return d;
    endfunction

    task automatic offer(input logic [DW-1:0] d, input int budget, output bit ok);
        ok = 0;
        data = d;
        data_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (data_ready) begin
                @(posedge clk);
                #1;
                model_accept(d);
                ok = 1;
                break;
            end
        end
        data_valid = 1'b0;
    endtask

    task automatic set_tready(input int mode);
        tready_mode = mode;
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tkeep !== '0 || tdata !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got tvalid=%b tlast=%b tkeep=%h, required all zero", tvalid, tlast, tkeep);
        end
        n_checks++;
        if (data_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ready_low: got %b, required 0", data_ready);
        end
        n_checks++;
        if (fifo_level !== '0 || frames_sent !== '0) begin
            n_errors++;
            $display("FAIL reset_counters: got level=%0d sent=%0d, required 0 0", fifo_level, frames_sent);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (data_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready_high: got %b, required 1", data_ready);
        end
    endtask

    task automatic test_single_frame();
        bit ok;
        set_tready(1);
        hs_count = 0;
        offer(ramp_frame(), 20, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL single_accept: got no accept, required accept");
        end
        n_checks++;
        if (tvalid !== 1'b0 || fifo_level !== LW'(1)) begin
            n_errors++;
            $display("FAIL single_push_edge: got tvalid=%b level=%0d, required 0 1", tvalid, fifo_level);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (tvalid !== 1'b1 || fifo_level !== '0 || tdata[15:0] !== 16'h0000) begin
            n_errors++;
            $display("FAIL single_latency: got tvalid=%b level=%0d tdata[15:0]=%h, required 1 0 0000",
                     tvalid, fifo_level, tdata[15:0]);
        end
        for (int i = 0; i < 100 && exp_data.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (hs_count !== BEATS) begin
            n_errors++;
            $display("FAIL single_beats: got %0d, required %0d", hs_count, BEATS);
        end
        n_checks++;
        if (last_keep !== 64'h1FFF_FFFF_FFFF_FFFF || last_data[AW-1:PAD_LO] !== '0) begin
            n_errors++;
            $display("FAIL single_last_keep_pad: got keep=%h pad=%h, required 1fffffffffffffff 0",
                     last_keep, last_data[AW-1:PAD_LO]);
        end
        n_checks++;
        if (frames_sent !== 32'd1 || tvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_done: got sent=%0d tvalid=%b, required 1 0", frames_sent, tvalid);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bad = 0;
        logic [SW-1:0] base;
        set_tready(1);
        hs_count = 0;
        rx_seq.delete();
        base = mdl_seq;
        for (int f = 0; f < 5; f++) begin
            offer(rand_frame(), 50, ok);
            if (!ok) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL b2b_accept: got %0d rejected, required 0", bad);
        end
        for (int i = 0; i < 200 && exp_data.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (hs_count != 5 * BEATS || hs_last - hs_first != 5 * BEATS - 1) begin
            n_errors++;
            $display("FAIL b2b_contiguous: got %0d beats over %0d cycles, required %0d over %0d",
                     hs_count, hs_last - hs_first + 1, 5 * BEATS, 5 * BEATS);
        end
        n_checks++;
        if (rx_seq.size() != 5 || rx_seq[0] !== base || rx_seq[4] !== SW'(base + 4)) begin
            n_errors++;
            $display("FAIL b2b_seq: got %0d frames first=%h, required 5 first=%h", rx_seq.size(),
                     (rx_seq.size() > 0) ? rx_seq[0] : '0, base);
        end
        n_checks++;
        if (frames_sent !== 32'(mdl_frames)) begin
            n_errors++;
            $display("FAIL b2b_sent: got %0d, required %0d", frames_sent, mdl_frames);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad = 0;
        set_tready(0);
        stab_viol = 0;
        for (int f = 0; f < 5; f++) begin
            offer(rand_frame(), 50, ok);
            if (!ok) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL bp_accept: got %0d rejected, required 0", bad);
        end
        n_checks++;
        if (data_ready !== 1'b0 || fifo_level !== LW'(DEP) || tvalid !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_full: got ready=%b level=%0d tvalid=%b, required 0 %0d 1",
                     data_ready, fifo_level, tvalid, DEP);
        end
        offer(rand_frame(), 5, ok);
        n_checks++;
        if (ok) begin
            n_errors++;
            $display("FAIL bp_reject: got accept while full, required no accept");
        end
        set_tready(1);
        for (int i = 0; i < 300 && exp_data.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_data.size() != 0 || frames_sent !== 32'(mdl_frames)) begin
            n_errors++;
            $display("FAIL bp_drain: got %0d beats left sent=%0d, required 0 %0d",
                     exp_data.size(), frames_sent, mdl_frames);
        end
        n_checks++;
        if (stab_viol != 0) begin
            n_errors++;
            $display("FAIL bp_stable: got %0d changes during stall, required 0", stab_viol);
        end
    endtask

    task automatic test_random_tready();
        bit ok;
        int bad = 0;
        set_tready(2);
        stab_viol = 0;
        for (int f = 0; f < 30; f++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            offer(rand_frame(), 300, ok);
            if (!ok) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL rand_accept: got %0d rejected, required 0", bad);
        end
        for (int i = 0; i < 5000 && exp_data.size() != 0; i++) @(posedge clk);
        set_tready(1);
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_data.size() != 0 || frames_sent !== 32'(mdl_frames)) begin
            n_errors++;
            $display("FAIL rand_drain: got %0d beats left sent=%0d, required 0 %0d",
                     exp_data.size(), frames_sent, mdl_frames);
        end
        n_checks++;
        if (stab_viol != 0) begin
            n_errors++;
            $display("FAIL rand_stable: got %0d changes during stall, required 0", stab_viol);
        end
    endtask

    task automatic test_seq_wrap();
        bit ok;
        int bad = 0;
        apply_reset();
        set_tready(1);
        rx_seq.delete();
        for (int f = 0; f < 257; f++) begin
            offer(rand_frame(), 100, ok);
            if (!ok) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL wrap_accept: got %0d rejected, required 0", bad);
        end
        for (int i = 0; i < 500 && exp_data.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (rx_seq.size() != 257 || rx_seq[255] !== 8'hFF || rx_seq[256] !== 8'h00) begin
            n_errors++;
            $display("FAIL wrap_seq: got %0d frames, required 257 with seq ff then 00", rx_seq.size());
        end
        n_checks++;
        if (frames_sent !== 32'd257) begin
            n_errors++;
            $display("FAIL wrap_sent: got %0d, required 257", frames_sent);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        set_tready(1);
        hs_count = 0;
        offer(rand_frame(), 20, ok);
        for (int i = 0; i < 50 && hs_count < 3; i++) @(negedge clk);
        n_checks++;
        if (hs_count < 3) begin
            n_errors++;
            $display("FAIL midrst_progress: got %0d beats, required 3", hs_count);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tkeep !== '0 || tdata !== '0 || data_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_outputs: got tvalid=%b tlast=%b tkeep=%h ready=%b, required all zero",
                     tvalid, tlast, tkeep, data_ready);
        end
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (fifo_level !== '0 || frames_sent !== '0 || data_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_release: got level=%0d sent=%0d ready=%b, required 0 0 1",
                     fifo_level, frames_sent, data_ready);
        end
        rx_seq.delete();
        offer(rand_frame(), 20, ok);
        for (int i = 0; i < 100 && exp_data.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (rx_seq.size() != 1 || rx_seq[0] !== '0 || frames_sent !== 32'd1) begin
            n_errors++;
            $display("FAIL midrst_restart: got %0d frames sent=%0d, required 1 frame seq 00 sent 1",
                     rx_seq.size(), frames_sent);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_random_tready();
        test_seq_wrap();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
